hm_sched: RTL and testbench
===========================

Name: hm_sched

Overview:
- Sequences the host-memory read transmitter across a contiguous physical region.
- Issues one memory-read request per STRIDE bytes and holds hm_addr stable while each request is in flight.
- Retries requests that hit a transmit timeout.
- Limits outstanding (issued, not completed) reads using completion pulses from the receive side.
- Sits between the CSR/control logic and the TLP transmitter, in the trn_clk domain.

Parameters:
- MAX_OUTSTANDING, 4, max issued-but-uncompleted reads (1..15).
- STRIDE, 128, byte increment between requests (32 DW, equals the requested length).
- RETRY_MAX, 3, transmit timeouts tolerated per request before error.
- CPL_TIMEOUT, 65535, drain-state cycles without a completion before error (16-bit counter).

Ports:
- trn_clk  in  1  clock
- sys_rst  in  1  reset
- start  in  1  one-cycle pulse; begins a run (ignored unless IDLE)
- abort  in  1  one-cycle pulse; stop issuing, drain, finish
- addr_base  in  64  first request address, sampled on start
- req_count  in  32  number of requests, sampled on start
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle pulse at end of run
- error  out  1  sticky; cleared on next accepted start
- tx_start  out  1  one-cycle pulse to transmitter
- hm_addr  out  64  request address to transmitter
- tx_end  in  1  transmitter finished the request
- tx_timeout  in  1  transmitter gave up on the request
- rx_cpl  in  1  pulse; one request's completion fully received
- stat_req_cpt  out  32  requests successfully transmitted
- stat_retry_cpt  out  32  transmit timeouts seen
- stat_state  out  2  current state encoding

Interface rule: one clock, trn_clk; reset is sys_rst, asynchronous and active-high.

Behaviour:
- Reset values:
  - Outputs: all outputs 0, state IDLE.
  - Internals: outstanding count 0, retry count 0, abort_pending 0, drain timer 0.
- States (2-bit, in this encoding order): IDLE, ISSUE, WAIT_TX, DRAIN.
- IDLE:
  - On start, latch cur_addr=addr_base and remaining=req_count, and clear error, abort_pending and retry count.
  - If req_count==0, pulse done next cycle and stay in IDLE; otherwise go to ISSUE.
- ISSUE:
  - If abort_pending, go to DRAIN.
  - Otherwise, if outstanding<MAX_OUTSTANDING: register tx_start=1 for exactly one cycle, drive hm_addr=cur_addr, go to WAIT_TX.
  - Latency: start sampled at cycle N gives tx_start high at N+2.
- WAIT_TX:
  - hm_addr is held constant; the transmitter evaluates it combinationally during the send.
  - On tx_end: outstanding+1, stat_req_cpt+1, cur_addr+=STRIDE, remaining-1, retry count=0. Go to DRAIN if remaining was 1 or abort_pending, else ISSUE.
  - On tx_timeout: stat_retry_cpt+1.
    - If retry count==RETRY_MAX: set error, go to DRAIN.
    - Otherwise retry count+1 and go to ISSUE with the same cur_addr.
  - tx_end and tx_timeout in the same cycle: tx_end wins.
- DRAIN:
  - Wait until outstanding==0, then pulse done and go to IDLE.
  - Drain timer increments each cycle with no rx_cpl and resets on rx_cpl.
  - When the timer reaches CPL_TIMEOUT: set error, force outstanding=0, pulse done, go to IDLE.
- Outstanding counter:
  - rx_cpl decrements it in any state.
  - Simultaneous increment and decrement leaves it unchanged.
  - rx_cpl while it is 0: ignore the decrement and set error.
- abort:
  - Sets abort_pending in any non-IDLE state; ignored in IDLE.
  - Never interrupts a request inside WAIT_TX; it is honoured after tx_end or tx_timeout.
- start while busy: ignored.
- Address arithmetic: 64-bit, wraps modulo 2^64. Crossing 4 GB needs no special handling because the transmitter selects 3DW/4DW per address.
- Counters: 32-bit, wrap silently.
- sys_rst mid-run: immediate return to reset values. No done pulse; tx_start is deasserted asynchronously.

Optional Feature:
- Macro HM_SCHED_THROTTLE_EN.
- When defined:
  - Adds input gap[15:0].
  - ISSUE additionally waits until at least gap cycles have elapsed since the last tx_end or tx_timeout.
  - gap==0 behaves as undefined.
- When undefined: no gap port. tx_start may assert 2 cycles after tx_end (WAIT_TX->ISSUE->tx_start).

Decomposition:
- Shared header hm.vh:
  - HM_SCHED_STATE_IDLE/ISSUE/WAIT_TX/DRAIN encodings.
  - HM_SCHED_STRIDE default.
  - HM_SCHED_CPL_TIMEOUT default.
- One sub-module, hm_sched_credit:
  - Outstanding up/down counter with saturation and underflow flag.
  - Outputs: can_issue (count<MAX_OUTSTANDING) and empty.

Test Plan:
- Lower-4GB run: addr_base=0x1000, req_count=3; transmitter acks tx_end 4 cycles after each tx_start; rx_cpl after each. Expect hm_addr 0x1000, 0x1080, 0x1100; stat_req_cpt=3; one done pulse; error=0.
- 4 GB crossing: addr_base=0xFFFF_FF80, req_count=2. Expect hm_addr 0xFFFF_FF80 then 0x1_0000_0000.
- Outstanding limit: MAX_OUTSTANDING=2, req_count=4, rx_cpl withheld. Expect exactly 2 tx_start, then stall in ISSUE. One rx_cpl releases exactly one more tx_start.
- Retry/error: tx_timeout on every attempt at 0x2000, RETRY_MAX=3. Expect 4 tx_start, all with hm_addr=0x2000; stat_retry_cpt=4; error=1; done pulse.
- Abort: abort pulsed mid-WAIT_TX of request 2 of 8. Expect no tx_start after that tx_end; done only after outstanding reaches 0.
- Reset/boundaries: req_count=0 gives done at N+1 with no tx_start. sys_rst during WAIT_TX clears busy, tx_start and counters asynchronously.

Source files
------------

// File: rtl/hm_sched_pkg.sv
// hm_sched_pkg: shared state encodings, defaults and address helper for the
// host-memory read scheduler.
package hm_sched_pkg;

  // Scheduler states; the encoding is visible on stat_state.
  typedef enum logic [1:0] {
    HM_SCHED_STATE_IDLE    = 2'd0,
    HM_SCHED_STATE_ISSUE   = 2'd1,
    HM_SCHED_STATE_WAIT_TX = 2'd2,
    HM_SCHED_STATE_DRAIN   = 2'd3
  } hm_state_e;

  // 128 bytes = 32 DW, the length of every read request.
  localparam int unsigned HM_SCHED_STRIDE      = 128;
  localparam int unsigned HM_SCHED_CPL_TIMEOUT = 65535;

  // Next request address; wraps modulo 2^64.
  function automatic logic [63:0] hm_next_addr(input logic [63:0] addr,
                                                input int unsigned stride);
    return addr + 64'(stride);
  endfunction

endpackage

// File: rtl/hm_sched_credit.sv
// hm_sched_credit: outstanding-read counter. Incremented when a request is
// transmitted, decremented when its completion has been received.
module hm_sched_credit #(
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic trn_clk,
  input  logic sys_rst,
  input  logic inc,
  input  logic dec,
  input  logic clear,
  output logic can_issue,
  output logic empty,
  output logic underflow
);

  logic [3:0] count;

  // Up/down count, saturating at MAX_OUTSTANDING and at zero.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values, independent of block ordering.
  always_ff @(posedge trn_clk or posedge sys_rst) begin
    if (sys_rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else begin
      unique case ({inc, dec})
        2'b10:   if (count != 4'(MAX_OUTSTANDING)) count <= count + 4'd1;
        2'b01:   if (count != 4'd0) count <= count - 4'd1;
        default: count <= count;
      endcase
    end
  end

  assign can_issue = (count < 4'(MAX_OUTSTANDING));
  assign empty     = (count == 4'd0);
  // A completion with nothing outstanding; a simultaneous issue pairs with it.
  assign underflow = dec & ~inc & (count == 4'd0);

endmodule

// File: rtl/hm_sched.sv
// hm_sched: issues one memory-read request per STRIDE bytes over a contiguous
// host region, retries transmit timeouts, limits outstanding reads and drains
// completions before reporting done.
// Optional build macro: HM_SCHED_THROTTLE_EN adds a gap[15:0] input that
// enforces a minimum idle gap after each tx_end/tx_timeout before re-issuing.
module hm_sched
  import hm_sched_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned STRIDE          = HM_SCHED_STRIDE,
  parameter int unsigned RETRY_MAX       = 3,
  parameter int unsigned CPL_TIMEOUT     = HM_SCHED_CPL_TIMEOUT
) (
  input  logic        trn_clk,
  input  logic        sys_rst,
  input  logic        start,
  input  logic        abort,
  input  logic [63:0] addr_base,
  input  logic [31:0] req_count,
`ifdef HM_SCHED_THROTTLE_EN
  input  logic [15:0] gap,
`endif
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic        tx_start,
  output logic [63:0] hm_addr,
  input  logic        tx_end,
  input  logic        tx_timeout,
  input  logic        rx_cpl,
  output logic [31:0] stat_req_cpt,
  output logic [31:0] stat_retry_cpt,
  output logic [1:0]  stat_state
);

  hm_state_e   state, state_d;
  logic [63:0] cur_addr;
  logic [31:0] remaining;
  logic [31:0] retry_cnt;
  logic        abort_pending;
  logic [15:0] drain_tmr;

  logic can_issue, cred_empty, cred_underflow, gap_ok;
  logic do_start, do_zero, do_issue, do_ack, do_retry, do_giveup;
  logic do_finish, do_tmo;

  hm_sched_credit #(.MAX_OUTSTANDING(MAX_OUTSTANDING)) u_credit (
    .trn_clk   (trn_clk),
    .sys_rst   (sys_rst),
    .inc       (do_ack),
    .dec       (rx_cpl),
    .clear     (do_tmo),
    .can_issue (can_issue),
    .empty     (cred_empty),
    .underflow (cred_underflow)
  );

`ifdef HM_SCHED_THROTTLE_EN
  logic [15:0] gap_cnt;

  // Cycles since the last transmit outcome, saturating; preset on start.
  always_ff @(posedge trn_clk or posedge sys_rst) begin
    if (sys_rst)                           gap_cnt <= '1;
    else if (do_start)                     gap_cnt <= '1;
    else if (do_ack | do_retry | do_giveup) gap_cnt <= '0;
    else if (gap_cnt != 16'hFFFF)          gap_cnt <= gap_cnt + 16'd1;
  end

  assign gap_ok = (gap_cnt >= gap);
`else
  assign gap_ok = 1'b1;
`endif

  // State register.
  always_ff @(posedge trn_clk or posedge sys_rst) begin
    if (sys_rst) state <= HM_SCHED_STATE_IDLE;
    else         state <= state_d;
  end

  // Next-state decode and single-cycle action strobes.
  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can infer a latch.
  always_comb begin
    state_d   = state;
    do_start  = 1'b0;
    do_zero   = 1'b0;
    do_issue  = 1'b0;
    do_ack    = 1'b0;
    do_retry  = 1'b0;
    do_giveup = 1'b0;
    do_finish = 1'b0;
    do_tmo    = 1'b0;
    unique case (state)
      HM_SCHED_STATE_IDLE: begin
        if (start) begin
          do_start = 1'b1;
          if (req_count == 32'd0) do_zero = 1'b1;
          else                    state_d = HM_SCHED_STATE_ISSUE;
        end
      end
      HM_SCHED_STATE_ISSUE: begin
        if (abort_pending) begin
          state_d = HM_SCHED_STATE_DRAIN;
        end else if (can_issue && gap_ok) begin
          do_issue = 1'b1;
          state_d  = HM_SCHED_STATE_WAIT_TX;
        end
      end
      HM_SCHED_STATE_WAIT_TX: begin
        // A request is never cut short; abort is honoured on its outcome.
        if (tx_end) begin
          do_ack  = 1'b1;
          state_d = (remaining == 32'd1 || abort_pending) ? HM_SCHED_STATE_DRAIN
                                                          : HM_SCHED_STATE_ISSUE;
        end else if (tx_timeout) begin
          if (retry_cnt == RETRY_MAX) begin
            do_giveup = 1'b1;
            state_d   = HM_SCHED_STATE_DRAIN;
          end else begin
            do_retry = 1'b1;
            state_d  = HM_SCHED_STATE_ISSUE;
          end
        end
      end
      HM_SCHED_STATE_DRAIN: begin
        if (cred_empty) begin
          do_finish = 1'b1;
          state_d   = HM_SCHED_STATE_IDLE;
        end else if (drain_tmr == 16'(CPL_TIMEOUT)) begin
          do_tmo  = 1'b1;
          state_d = HM_SCHED_STATE_IDLE;
        end
      end
      default: state_d = HM_SCHED_STATE_IDLE;
    endcase
  end

  // Run context, registered outputs and statistics.
  always_ff @(posedge trn_clk or posedge sys_rst) begin
    if (sys_rst) begin
      cur_addr       <= '0;
      remaining      <= '0;
      retry_cnt      <= '0;
      abort_pending  <= 1'b0;
      drain_tmr      <= '0;
      done           <= 1'b0;
      error          <= 1'b0;
      tx_start       <= 1'b0;
      hm_addr        <= '0;
      stat_req_cpt   <= '0;
      stat_retry_cpt <= '0;
    end else begin
      done     <= do_zero | do_finish | do_tmo;
      tx_start <= do_issue;

      if (do_start) begin
        cur_addr      <= addr_base;
        remaining     <= req_count;
        retry_cnt     <= '0;
        abort_pending <= 1'b0;
      end else if (abort && state != HM_SCHED_STATE_IDLE) begin
        abort_pending <= 1'b1;
      end

      if (do_issue) hm_addr <= cur_addr;

      if (do_ack) begin
        stat_req_cpt <= stat_req_cpt + 32'd1;
        cur_addr     <= hm_next_addr(cur_addr, STRIDE);
        remaining    <= remaining - 32'd1;
        retry_cnt    <= '0;
      end

      if (do_retry | do_giveup) stat_retry_cpt <= stat_retry_cpt + 32'd1;
      if (do_retry)             retry_cnt      <= retry_cnt + 32'd1;

      // Later assignment wins: a fault in the start cycle still sticks.
      if (do_start)                          error <= 1'b0;
      if (do_giveup | do_tmo | cred_underflow) error <= 1'b1;

      // Counts completion-free cycles while draining.
      if (state != HM_SCHED_STATE_DRAIN || rx_cpl) drain_tmr <= '0;
      else if (drain_tmr != 16'hFFFF)              drain_tmr <= drain_tmr + 16'd1;
    end
  end

  assign busy       = (state != HM_SCHED_STATE_IDLE);
  assign stat_state = state;

endmodule

// File: tb/tb_hm_sched.sv
// tb_hm_sched: directed checks of hm_sched (MAX_OUTSTANDING=2, CPL_TIMEOUT=40).
// Inputs are driven and outputs sampled on the falling edge of trn_clk.
module tb_hm_sched;

  logic        trn_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        start = 1'b0, abort = 1'b0;
  logic [63:0] addr_base = '0;
  logic [31:0] req_count = '0;
  logic        busy, done, error, tx_start;
  logic [63:0] hm_addr;
  logic        tx_end = 1'b0, tx_timeout = 1'b0, rx_cpl = 1'b0;
  logic [31:0] stat_req_cpt, stat_retry_cpt;
  logic [1:0]  stat_state;

  int checks = 0;
  int errors = 0;
  int exp_req = 0;
  int exp_retry = 0;

  hm_sched #(.MAX_OUTSTANDING(2), .CPL_TIMEOUT(40)) dut (
    .trn_clk(trn_clk), .sys_rst(sys_rst), .start(start), .abort(abort),
    .addr_base(addr_base), .req_count(req_count), .busy(busy), .done(done),
    .error(error), .tx_start(tx_start), .hm_addr(hm_addr), .tx_end(tx_end),
    .tx_timeout(tx_timeout), .rx_cpl(rx_cpl), .stat_req_cpt(stat_req_cpt),
    .stat_retry_cpt(stat_retry_cpt), .stat_state(stat_state)
  );

  always #5 trn_clk = ~trn_clk;

  task automatic tick();
    @(negedge trn_clk);
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start(input logic [63:0] base, input logic [31:0] cnt);
    addr_base = base;
    req_count = cnt;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_start();
    int n = 0;
    while (tx_start !== 1'b1 && n < 60) begin tick(); n++; end
    check("tx_start_seen", tx_start, 1'b1);
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (done !== 1'b1 && n < 120) begin tick(); n++; end
    check("done_seen", done, 1'b1);
    tick();
    check("done_one_cycle", done, 1'b0);
    check("idle_after_done", busy, 1'b0);
  endtask

  // Plays the transmitter for one request: ack 4 cycles after tx_start.
  task automatic serve(input logic [63:0] exp_addr, input bit timeout,
                       input bit give_cpl, input bit do_abort);
    wait_start();
    check("hm_addr", hm_addr, exp_addr);
    tick();
    check("tx_start_pulse", tx_start, 1'b0);
    if (do_abort) abort = 1'b1;
    tick();
    abort = 1'b0;
    tick();
    check("hm_addr_hold", hm_addr, exp_addr);
    if (timeout) begin tx_timeout = 1'b1; exp_retry++; end
    else         begin tx_end = 1'b1;     exp_req++;   end
    tick();
    tx_end = 1'b0;
    tx_timeout = 1'b0;
    if (give_cpl) begin rx_cpl = 1'b1; tick(); rx_cpl = 1'b0; end
  endtask

  // Idles n cycles, reporting whether tx_start or done rose meanwhile.
  task automatic quiet(input int n, output bit saw_start, output bit saw_done);
    saw_start = 1'b0;
    saw_done = 1'b0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (tx_start) saw_start = 1'b1;
      if (done) saw_done = 1'b1;
    end
  endtask

  initial begin
    int  n;
    bit  s, d;

    // Reset values.
    tick();
    check("rst_busy", busy, 1'b0);
    check("rst_tx_start", tx_start, 1'b0);
    check("rst_hm_addr", hm_addr, 64'h0);
    check("rst_state", stat_state, 2'd0);
    tick();
    sys_rst = 1'b0;
    tick();
    check("rst_done", done, 1'b0);
    check("rst_error", error, 1'b0);
    check("rst_req_cpt", stat_req_cpt, 32'd0);

    // Lower-4GB run with start-to-tx_start latency.
    pulse_start(64'h1000, 32'd3);
    check("lat_state_issue", stat_state, 2'd1);
    check("lat_no_start_n1", tx_start, 1'b0);
    tick();
    check("lat_start_n2", tx_start, 1'b1);
    serve(64'h1000, 1'b0, 1'b1, 1'b0);
    serve(64'h1080, 1'b0, 1'b1, 1'b0);
    serve(64'h1100, 1'b0, 1'b1, 1'b0);
    wait_done(n);
    check("low_req_cpt", stat_req_cpt, 32'(exp_req));
    check("low_error", error, 1'b0);

    // 4 GB crossing.
    pulse_start(64'hFFFF_FF80, 32'd2);
    serve(64'hFFFF_FF80, 1'b0, 1'b1, 1'b0);
    serve(64'h1_0000_0000, 1'b0, 1'b1, 1'b0);
    wait_done(n);
    check("x4g_req_cpt", stat_req_cpt, 32'(exp_req));

    // Outstanding limit of 2 with completions withheld.
    pulse_start(64'h3000, 32'd4);
    serve(64'h3000, 1'b0, 1'b0, 1'b0);
    serve(64'h3080, 1'b0, 1'b0, 1'b0);
    quiet(8, s, d);
    check("limit_stall", s, 1'b0);
    check("limit_in_issue", stat_state, 2'd1);
    rx_cpl = 1'b1; tick(); rx_cpl = 1'b0;
    serve(64'h3100, 1'b0, 1'b0, 1'b0);
    quiet(6, s, d);
    check("limit_one_more", s, 1'b0);
    rx_cpl = 1'b1; tick(); rx_cpl = 1'b0;
    serve(64'h3180, 1'b0, 1'b0, 1'b0);
    check("limit_drain", stat_state, 2'd3);
    rx_cpl = 1'b1; tick(); tick(); rx_cpl = 1'b0;
    wait_done(n);
    check("limit_error", error, 1'b0);

    // Retry exhaustion at 0x2000.
    pulse_start(64'h2000, 32'd1);
    for (int i = 0; i < 4; i++) serve(64'h2000, 1'b1, 1'b0, 1'b0);
    wait_done(n);
    check("retry_cpt", stat_retry_cpt, 32'(exp_retry));
    check("retry_error", error, 1'b1);
    check("retry_req_cpt", stat_req_cpt, 32'(exp_req));

    // Abort during request 2 of 8; error cleared by this start.
    pulse_start(64'h4000, 32'd8);
    check("start_clears_error", error, 1'b0);
    serve(64'h4000, 1'b0, 1'b1, 1'b0);
    serve(64'h4080, 1'b0, 1'b0, 1'b1);
    quiet(6, s, d);
    check("abort_no_start", s, 1'b0);
    check("abort_no_early_done", d, 1'b0);
    check("abort_drain", stat_state, 2'd3);
    rx_cpl = 1'b1; tick(); rx_cpl = 1'b0;
    wait_done(n);
    check("abort_req_cpt", stat_req_cpt, 32'(exp_req));

    // Zero-length run: done one cycle after start, no request.
    pulse_start(64'h9000, 32'd0);
    check("zero_done", done, 1'b1);
    check("zero_busy", busy, 1'b0);
    check("zero_no_start", tx_start, 1'b0);
    tick();
    check("zero_done_pulse", done, 1'b0);

    // Completion with nothing outstanding.
    rx_cpl = 1'b1; tick(); rx_cpl = 1'b0;
    check("underflow_error", error, 1'b1);

    // Completion timeout while draining.
    pulse_start(64'h6000, 32'd1);
    check("tmo_error_clr", error, 1'b0);
    serve(64'h6000, 1'b0, 1'b0, 1'b0);
    wait_done(n);
    check("tmo_latency", (n >= 39 && n <= 43), 1'b1);
    check("tmo_error", error, 1'b1);

    // Counter was forced to zero: a clean run drains promptly.
    pulse_start(64'h7000, 32'd1);
    serve(64'h7000, 1'b0, 1'b1, 1'b0);
    wait_done(n);
    check("post_tmo_fast", (n < 5), 1'b1);
    check("post_tmo_error", error, 1'b0);

    // Asynchronous reset while tx_start is high.
    pulse_start(64'h5000, 32'd2);
    wait_start();
    #2 sys_rst = 1'b1;
    #1;
    check("arst_tx_start", tx_start, 1'b0);
    check("arst_busy", busy, 1'b0);
    check("arst_req_cpt", stat_req_cpt, 32'd0);
    check("arst_retry_cpt", stat_retry_cpt, 32'd0);
    exp_req = 0;
    exp_retry = 0;
    tick();
    sys_rst = 1'b0;
    quiet(3, s, d);
    check("arst_no_done", d, 1'b0);
    check("arst_state", stat_state, 2'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Hard stop if the directed sequence ever stalls.
  initial begin
    #200000;
    $display("FAIL watchdog_timeout observed=stalled expected=finished");
    $fatal(1, "watchdog");
  end

endmodule
